cache_line_ctrl: RTL

//  Direct-mapped, write-through, no-write-allocate cache controller; initiator side of the main-memory

---
 rtl/cache_pkg.sv | 18 +
 rtl/cache_line_store.sv | 54 +++++
 rtl/cache_line_ctrl.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// cache_pkg: shared types, geometry helpers and word/byte select for the line cache.
package cache_pkg;
    typedef enum logic [1:0] {S_IDLE, S_FILL, S_WRITE, S_RESP} state_t;
    localparam int OFFSET_W = 5;
    localparam int WORDS_PER_LINE = 8;
    typedef logic [32*WORDS_PER_LINE-1:0] line_t;
    function automatic int index_w(input int num_lines);
        return $clog2(num_lines);
    endfunction
    function automatic int tag_w(input int addr_w, input int num_lines);
        return addr_w - OFFSET_W - $clog2(num_lines);
    endfunction
    function automatic logic [31:0] sel_data(input line_t line, input logic [4:0] off, input logic bw);
        logic [31:0] wd;
        wd = line[{off[4:2], 5'b0} +: 32];
        return bw ? wd : {24'h0, wd[{off[1:0], 3'b0} +: 8]};
    endfunction
endpackage

// File: rtl/cache_line_store.sv
// cache_line_store: valid/tag/data arrays with a comb read port, line fill and word/byte merge writes.
module cache_line_store
    import cache_pkg::*;
#(
    parameter int NUM_LINES = 8,
    parameter int IDX_W = 3,
    parameter int TAG_W = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_valid,
    output logic [TAG_W-1:0] rd_tag,
    output line_t            rd_line,
    input  logic             lw_en,
    input  logic [IDX_W-1:0] lw_idx,
    input  logic [TAG_W-1:0] lw_tag,
    input  line_t            lw_line,
    input  logic             ww_en,
    input  logic [IDX_W-1:0] ww_idx,
    input  logic [2:0]       ww_word,
    input  logic [1:0]       ww_lane,
    input  logic             ww_bw,
    input  logic [31:0]      ww_data
);
    logic [NUM_LINES-1:0] r_valid;
    logic [TAG_W-1:0]     r_tag  [NUM_LINES];
    line_t                r_data [NUM_LINES];

    assign rd_valid = r_valid[rd_idx];
    assign rd_tag   = r_tag[rd_idx];
    assign rd_line  = r_data[rd_idx];

    // a fill after a flush in the same edge keeps its line valid
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= '0;
        end else begin
            if (flush) r_valid <= '0;
            if (lw_en) r_valid[lw_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (lw_en) begin
            r_tag[lw_idx]  <= lw_tag;
            r_data[lw_idx] <= lw_line;
        end else if (ww_en) begin
            if (ww_bw) r_data[ww_idx][{ww_word, 5'b0} +: 32] <= ww_data;
            else r_data[ww_idx][{ww_word, ww_lane, 3'b0} +: 8] <= ww_data[7:0];
        end
    end
endmodule

// File: rtl/cache_line_ctrl.sv
// cache_line_ctrl: direct-mapped write-through, no-write-allocate cache controller.
// Serves load hits locally, fills lines on load misses, forwards every store to memory.
module cache_line_ctrl
    import cache_pkg::*;
#(
    parameter int NUM_LINES = 8,
    parameter int LINE_BITS = 256,
    parameter int ADDR_W = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cpu_req_i,
    input  logic                 cpu_we_i,
    input  logic                 cpu_bw_i,
    input  logic [ADDR_W-1:0]    cpu_addr_i,
    input  logic [31:0]          cpu_wdata_i,
    input  logic                 flush_i,
    output logic [31:0]          cpu_rdata_o,
    output logic                 cpu_ready_o,
    output logic [ADDR_W-1:0]    mem_addr_o,
    output logic [31:0]          mem_wdata_o,
    output logic                 mem_ce_n_o,
    output logic                 mem_oe_n_o,
    output logic                 mem_we_n_o,
    output logic                 mem_bw_o,
    output logic                 mem_multiple_read_o,
    input  logic [LINE_BITS-1:0] mem_line_i,
    input  logic                 mem_line_full_n_i,
    input  logic                 mem_hold_i,
    output logic [31:0]          hit_count_o,
    output logic [31:0]          miss_count_o
);
    localparam int IDX_W = index_w(NUM_LINES);
    localparam int TAG_W = tag_w(ADDR_W, NUM_LINES);

    state_t            r_state, w_next;
    logic              r_bw, r_first, r_flush_pend;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [ADDR_W-1:0] w_addr;
    logic              w_rd_valid, w_hit, w_flush, w_start, w_line_ok;
    logic              w_load_hit, w_load_miss, w_lw_en, w_ww_en;
    logic [TAG_W-1:0]  w_rd_tag;
    line_t             w_rd_line;
    logic [31:0]       w_rdata_nxt;

    // the read port looks at the incoming request in IDLE and at the latched one afterwards
    assign w_addr    = (r_state == S_IDLE) ? cpu_addr_i : r_addr;
    assign w_hit     = w_rd_valid && (w_rd_tag == w_addr[ADDR_W-1 -: TAG_W]);
    assign w_flush   = (r_state == S_IDLE) && (flush_i || r_flush_pend);
    assign w_start   = (r_state == S_IDLE) && cpu_req_i && !w_flush;
    assign w_line_ok = (r_state == S_FILL) && !r_first && !mem_hold_i && !mem_line_full_n_i;

    cache_line_store #(.NUM_LINES(NUM_LINES), .IDX_W(IDX_W), .TAG_W(TAG_W)) u_store (
        .clk      (clk),
        .reset    (reset),
        .flush    (w_flush),
        .rd_idx   (w_addr[OFFSET_W +: IDX_W]),
        .rd_valid (w_rd_valid),
        .rd_tag   (w_rd_tag),
        .rd_line  (w_rd_line),
        .lw_en    (w_lw_en),
        .lw_idx   (r_addr[OFFSET_W +: IDX_W]),
        .lw_tag   (r_addr[ADDR_W-1 -: TAG_W]),
        .lw_line  (mem_line_i),
        .ww_en    (w_ww_en),
        .ww_idx   (r_addr[OFFSET_W +: IDX_W]),
        .ww_word  (r_addr[4:2]),
        .ww_lane  (r_addr[1:0]),
        .ww_bw    (r_bw),
        .ww_data  (r_wdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_first      <= 1'b0;
            r_flush_pend <= 1'b0;
            r_bw         <= 1'b1;
            r_addr       <= '0;
            r_wdata      <= '0;
        end else begin
            r_state      <= w_next;
            r_first      <= w_start;
            r_flush_pend <= (r_state != S_IDLE) && (r_flush_pend || flush_i);
            if (w_start) begin
                r_bw    <= cpu_bw_i;
                r_addr  <= cpu_addr_i;
                r_wdata <= cpu_wdata_i;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_next = cpu_we_i ? S_WRITE : (w_hit ? S_RESP : S_FILL);
            S_FILL:  if (w_line_ok) w_next = S_RESP;
            S_WRITE: w_next = S_RESP;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_load_hit  = w_start && !cpu_we_i && w_hit;
        w_load_miss = w_start && !cpu_we_i && !w_hit;
        w_lw_en     = w_line_ok && !reset;
        w_ww_en     = (r_state == S_WRITE) && w_hit && !reset;
        w_rdata_nxt = w_load_hit ? sel_data(w_rd_line, cpu_addr_i[4:0], cpu_bw_i) :
                      w_line_ok  ? sel_data(mem_line_i, r_addr[4:0], r_bw) : cpu_rdata_o;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cpu_ready_o         <= 1'b0;
            cpu_rdata_o         <= '0;
            mem_addr_o          <= '0;
            mem_wdata_o         <= '0;
            mem_ce_n_o          <= 1'b1;
            mem_oe_n_o          <= 1'b1;
            mem_we_n_o          <= 1'b1;
            mem_bw_o            <= 1'b1;
            mem_multiple_read_o <= 1'b0;
            hit_count_o         <= '0;
            miss_count_o        <= '0;
        end else begin
            cpu_ready_o         <= (w_next == S_RESP);
            cpu_rdata_o         <= w_rdata_nxt;
            mem_ce_n_o          <= !((w_next == S_FILL) || (w_next == S_WRITE));
            mem_oe_n_o          <= (w_next != S_FILL);
            mem_we_n_o          <= (w_next != S_WRITE);
            mem_multiple_read_o <= 1'b0;
            if (w_load_miss) begin
                mem_addr_o <= {cpu_addr_i[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
                mem_bw_o   <= 1'b1;
            end
            if (w_start && cpu_we_i) begin
                mem_addr_o  <= cpu_addr_i;
                mem_bw_o    <= cpu_bw_i;
                mem_wdata_o <= cpu_wdata_i;
            end
            if (w_load_hit && (hit_count_o != '1)) hit_count_o <= hit_count_o + 32'd1;
            if (w_load_miss && (miss_count_o != '1)) miss_count_o <= miss_count_o + 32'd1;
        end
    end
endmodule
